score_display: RTL and testbench
================================

# score_display

Parametrised score accumulator and multiplexed seven-segment driver for the game top level. It holds an N-digit BCD score, adds per-event points, and scans the digits onto a shared active-low segment bus with active-low anodes. The scan is paced by an internal divider running on the 100 MHz master clock, which replaces the separate derived segment clock.

## Interface

Parameters:
- NUM_DIGITS, 4: number of BCD digits and anodes (1..8).
- SCAN_DIV, 100000: clk cycles each digit is displayed (≥2).
- SATURATE, 1: 1 = clamp at all-nines on overflow; 0 = wrap modulo 10^NUM_DIGITS.

Ports:
- clk  in  1  master clock, 100 MHz.
- rst  in  1  reset. Synchronous, active-high.
- add_pulse  in  1  one-cycle strobe; add add_value to the score.
- add_value  in  4  points to add, 0..9. Values 10..15 are treated as 9.
- clear  in  1  zero the score and the overflow flag.
- pause  in  1  while high, add_pulse is ignored; the scan continues.
- score_bcd  out  4*NUM_DIGITS  current score; digit 0 (ones) is in bits [3:0].
- overflow  out  1  sticky; set when an add exceeds all-nines.
- seg  out  7  segments, active-low, bit0=a … bit6=g.
- an  out  NUM_DIGITS  anodes, active-low, one-hot. an[NUM_DIGITS-1] is the leftmost digit.

## Operation

- **Score update**, one cycle, priority order:
  - rst: clears everything.
  - clear: score_bcd=0, overflow=0.
  - add_pulse & !pause: ripple-carry BCD add of the clamped value into digit 0, carry propagating through all digits in the same cycle.
  - otherwise: hold.
- **Overflow**, when the carry leaves the top digit:
  - SATURATE=1: score becomes all nines.
  - SATURATE=0: keep the wrapped sum.
  - Both modes: overflow←1, and it stays set until clear or rst.
  - Saturated score plus add_value=0: no change, overflow unchanged.
- **Scan divider**: div_cnt counts 0..SCAN_DIV-1. At terminal count it wraps to 0, and the digit index advances NUM_DIGITS-1 → … → 0 → NUM_DIGITS-1 (leftmost first).
- **Scan FSM**, two states:
  - IDLE (after reset): an all ones, seg 7'h7F.
  - SCAN: entered at the first terminal count and held until rst.
- **Digit output**: in SCAN, at each terminal count, an and seg are registered from the new index and the current score_bcd. A BCD digit >9 cannot occur.
- **Decoder**: 0..9 map to standard glyphs.
- **Effect of clear**: does not disturb the scan.
- **Effect of rst mid-scan**: returns to IDLE, div_cnt=0, index=NUM_DIGITS-1.

## Timing

- Reset values: score_bcd=0, overflow=0, seg=7'h7F, an={NUM_DIGITS{1}}, div_cnt=0, index=NUM_DIGITS-1.
- score_bcd and overflow are registered and valid the cycle after add_pulse is sampled.
- Back-to-back add_pulse on consecutive cycles: every pulse is accumulated; none are dropped.
- First lit digit: the cycle after div_cnt reaches SCAN_DIV-1 following reset, i.e. SCAN_DIV cycles after rst deasserts.
- Each digit is held for exactly SCAN_DIV cycles. One full frame is NUM_DIGITS*SCAN_DIV cycles.
- A score change is shown from the next digit-advance that selects the affected digit. No mid-digit glitch, because seg only changes at the advance.

## Configuration

- SCORE_DISPLAY_BLANK_EN defined: leading-zero blanking.
  - Digit i≥1 is blanked when it and every higher digit are zero.
  - During a blanked digit's slot: an all ones and seg 7'h7F, with slot duration unchanged.
  - Digit 0 is never blanked.
- Undefined: all digits are always driven, including leading zeros.

## Structure

- Package score_display_pkg holds:
  - the seven-segment glyph constants SEG_0..SEG_9 and SEG_OFF;
  - the BCD digit width localparam (4);
  - the scan-state typedef (IDLE, SCAN).
- One sub-module, bcd_seven_seg: combinational 4-bit BCD to 7-bit active-low decoder, instantiated once on the selected digit.
- The BCD adder chain stays inline as a generate loop.

## Test plan

- **Reset**: rst high for 3 cycles → score_bcd=0, overflow=0, an=4'b1111, seg=7'h7F. With SCAN_DIV=4, the first an=4'b0111 appears 4 cycles after release.
- **Carry chain**: score 0x0098, add_pulse with add_value=5 → 0x0103 next cycle. add_value=12 on 0x0000 → 0x0009.
- **Saturate**: SATURATE=1, score 0x9995, add 7 → 0x9999, overflow=1. A following clear → 0x0000, overflow=0.
- **Wrap**: SATURATE=0, score 0x9995, add 7 → 0x0002, overflow=1.
- **Scan order**: SCAN_DIV=4, score 0x1234 → an sequence 0111,1011,1101,1110 with seg = glyphs for 1,2,3,4, each held 4 cycles, repeating. With SCORE_DISPLAY_BLANK_EN and score 0x0007: three blank slots, then an=1110 showing 7.
- **Priority**: clear and add_pulse in the same cycle → score 0. pause high with add_pulse → score unchanged. Three consecutive add_pulse of 3 → +9 total.

Source files
------------

// File: rtl/score_display_pkg.sv
`default_nettype none
// ============================================================================
// Module      : score_display_pkg
// Description : Shared glyphs, BCD width and scan-state type for score_display.
// Revision    : 1.0 - initial release
// ============================================================================
package score_display_pkg;

    localparam int BCD_W = 4;

    // Active-low glyphs, bit0 = a ... bit6 = g
    localparam logic [6:0] SEG_0   = 7'h40;
    localparam logic [6:0] SEG_1   = 7'h79;
    localparam logic [6:0] SEG_2   = 7'h24;
    localparam logic [6:0] SEG_3   = 7'h30;
    localparam logic [6:0] SEG_4   = 7'h19;
    localparam logic [6:0] SEG_5   = 7'h12;
    localparam logic [6:0] SEG_6   = 7'h02;
    localparam logic [6:0] SEG_7   = 7'h78;
    localparam logic [6:0] SEG_8   = 7'h00;
    localparam logic [6:0] SEG_9   = 7'h10;
    localparam logic [6:0] SEG_OFF = 7'h7F;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SCAN = 1'b1
    } scan_state_t;

endpackage
`default_nettype wire

// File: rtl/bcd_seven_seg.sv
`default_nettype none
// ============================================================================
// Module      : bcd_seven_seg
// Description : Combinational BCD digit to active-low seven-segment decoder.
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_seven_seg
    import score_display_pkg::*;
(
    input  logic [BCD_W-1:0] i_bcd,
    output logic [6:0]       o_seg
);

    always_comb begin
        o_seg = SEG_OFF;
        case (i_bcd)
            4'd0:    o_seg = SEG_0;
            4'd1:    o_seg = SEG_1;
            4'd2:    o_seg = SEG_2;
            4'd3:    o_seg = SEG_3;
            4'd4:    o_seg = SEG_4;
            4'd5:    o_seg = SEG_5;
            4'd6:    o_seg = SEG_6;
            4'd7:    o_seg = SEG_7;
            4'd8:    o_seg = SEG_8;
            4'd9:    o_seg = SEG_9;
            default: o_seg = SEG_OFF;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/score_display.sv
`default_nettype none
// ============================================================================
// Module      : score_display
// Description : N-digit BCD score accumulator with multiplexed 7-seg scan.
//               Define SCORE_DISPLAY_BLANK_EN for leading-zero blanking.
// Revision    : 1.0 - initial release
// ============================================================================
module score_display
    import score_display_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 100000,
    parameter int SATURATE   = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        add_pulse,
    input  logic [3:0]                  add_value,
    input  logic                        clear,
    input  logic                        pause,
    output logic [BCD_W*NUM_DIGITS-1:0] score_bcd,
    output logic                        overflow,
    output logic [6:0]                  seg,
    output logic [NUM_DIGITS-1:0]       an
);

    localparam int SCORE_W = BCD_W * NUM_DIGITS;
    localparam int DIV_W   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [DIV_W-1:0]   DIV_LAST  = DIV_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0]   IDX_TOP   = IDX_W'(NUM_DIGITS - 1);
    localparam logic [SCORE_W-1:0] ALL_NINES = {NUM_DIGITS{4'h9}};

    logic [SCORE_W-1:0]    score_q, score_d;
    logic                  overflow_q, overflow_d;
    scan_state_t           state_q, state_d;
    logic [DIV_W-1:0]      div_cnt_q, div_cnt_d;
    logic [IDX_W-1:0]      index_q, index_d;
    logic [6:0]            seg_q, seg_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;

    logic [3:0]            w_add_clamped;
    logic [NUM_DIGITS:0]   w_carry;
    logic [SCORE_W-1:0]    w_sum_bcd;
    logic                  w_tc;
    logic [IDX_W-1:0]      w_next_idx;
    logic [BCD_W-1:0]      w_digit;
    logic [NUM_DIGITS-1:0] w_onehot;
    logic [6:0]            w_glyph;
    logic                  w_blank;

    assign w_add_clamped = (add_value > 4'd9) ? 4'd9 : add_value;
    assign w_carry[0]    = 1'b0;

    // Single-cycle ripple-carry BCD add; only digit 0 receives the points
    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_bcd_add
        logic [3:0] w_addend;
        logic [4:0] w_raw;
        if (i == 0) begin : g_lsd
            assign w_addend = w_add_clamped;
        end else begin : g_upper
            assign w_addend = 4'd0;
        end
        assign w_raw = {1'b0, score_q[i*BCD_W +: BCD_W]} + {1'b0, w_addend} + {4'd0, w_carry[i]};
        assign w_carry[i+1] = (w_raw > 5'd9);
        assign w_sum_bcd[i*BCD_W +: BCD_W] = w_carry[i+1] ? 4'(w_raw - 5'd10) : w_raw[3:0];
    end

    always_comb begin
        score_d    = score_q;
        overflow_d = overflow_q;
        if (clear) begin
            score_d    = '0;
            overflow_d = 1'b0;
        end else if (add_pulse && !pause) begin
            score_d = w_sum_bcd;
            if (w_carry[NUM_DIGITS]) begin
                overflow_d = 1'b1;
                if (SATURATE != 0) begin
                    score_d = ALL_NINES;
                end
            end
        end
    end

    assign w_tc      = (div_cnt_q == DIV_LAST);
    assign div_cnt_d = w_tc ? '0 : div_cnt_q + 1'b1;

    // The first terminal count lights the current (leftmost) index without advancing
    always_comb begin
        w_next_idx = index_q;
        if (state_q == SCAN) begin
            w_next_idx = (index_q == '0) ? IDX_TOP : index_q - 1'b1;
        end
    end

    always_comb begin
        w_digit  = '0;
        w_onehot = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (w_next_idx == IDX_W'(i)) begin
                w_digit     = score_q[i*BCD_W +: BCD_W];
                w_onehot[i] = 1'b1;
            end
        end
    end

`ifdef SCORE_DISPLAY_BLANK_EN
    logic [NUM_DIGITS-1:0] w_lead_zero;

    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_lead_zero
        if (i == NUM_DIGITS - 1) begin : g_top
            assign w_lead_zero[i] = (score_q[i*BCD_W +: BCD_W] == 4'd0);
        end else begin : g_lower
            assign w_lead_zero[i] = (score_q[i*BCD_W +: BCD_W] == 4'd0) && w_lead_zero[i+1];
        end
    end

    always_comb begin
        w_blank = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (w_next_idx == IDX_W'(i)) begin
                w_blank = (i != 0) && w_lead_zero[i];
            end
        end
    end
`else
    assign w_blank = 1'b0;
`endif

    bcd_seven_seg u_dec (
        .i_bcd (w_digit),
        .o_seg (w_glyph)
    );

    // Scan FSM: state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Scan FSM: next state
    always_comb begin
        state_d = state_q;
        if (state_q == IDLE && w_tc) begin
            state_d = SCAN;
        end
    end

    // Scan FSM: outputs, updated only at a digit advance
    always_comb begin
        index_d = index_q;
        seg_d   = seg_q;
        an_d    = an_q;
        if (w_tc) begin
            index_d = w_next_idx;
            if (w_blank) begin
                seg_d = SEG_OFF;
                an_d  = '1;
            end else begin
                seg_d = w_glyph;
                an_d  = ~w_onehot;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            score_q    <= '0;
            overflow_q <= 1'b0;
            div_cnt_q  <= '0;
            index_q    <= IDX_TOP;
            seg_q      <= SEG_OFF;
            an_q       <= '1;
        end else begin
            score_q    <= score_d;
            overflow_q <= overflow_d;
            div_cnt_q  <= div_cnt_d;
            index_q    <= index_d;
            seg_q      <= seg_d;
            an_q       <= an_d;
        end
    end

    assign score_bcd = score_q;
    assign overflow  = overflow_q;
    assign seg       = seg_q;
    assign an        = an_q;

endmodule
`default_nettype wire

// File: tb/tb_score_display.sv
`default_nettype none
// ============================================================================
// Module      : tb_score_display
// Description : Self-checking bench for score_display (saturating and wrapping).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_score_display;

    localparam int N   = 4;
    localparam int DIV = 4;

    logic           clk = 1'b0;
    logic           rst, add_pulse, clear, pause;
    logic [3:0]     add_value;
    logic [4*N-1:0] score_s, score_w;
    logic           ovf_s, ovf_w;
    logic [6:0]     seg_s, seg_w;
    logic [N-1:0]   an_s, an_w;

    always #5 clk = ~clk;

    score_display #(.NUM_DIGITS(N), .SCAN_DIV(DIV), .SATURATE(1)) u_sat (
        .clk(clk), .rst(rst), .add_pulse(add_pulse), .add_value(add_value),
        .clear(clear), .pause(pause), .score_bcd(score_s), .overflow(ovf_s),
        .seg(seg_s), .an(an_s)
    );

    score_display #(.NUM_DIGITS(N), .SCAN_DIV(DIV), .SATURATE(0)) u_wrap (
        .clk(clk), .rst(rst), .add_pulse(add_pulse), .add_value(add_value),
        .clear(clear), .pause(pause), .score_bcd(score_w), .overflow(ovf_w),
        .seg(seg_w), .an(an_w)
    );

    typedef struct {
        logic           clr;
        logic           pse;
        logic           add;
        logic [3:0]     val;
        logic [4*N-1:0] exp_score;
        logic           exp_ovf;
    } vec_t;

    logic [6:0]   glyph [10];
    int           m_score [2];
    bit           m_ovf   [2];
    logic [6:0]   m_seg   [2];
    logic [N-1:0] m_an    [2];
    int           k;
    int           checks = 0;
    int           passes = 0;

    function automatic int pow10(input int d);
        int r = 1;
        for (int i = 0; i < d; i++) r = r * 10;
        return r;
    endfunction

    function automatic logic [4*N-1:0] to_bcd(input int s);
        logic [4*N-1:0] r = '0;
        for (int i = 0; i < N; i++) r[4*i +: 4] = 4'((s / pow10(i)) % 10);
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // One clock: advance the reference model with the inputs seen at the edge, then compare.
    task automatic step();
        int d, dig, s, v;
        bit blank;
        logic [N-1:0] oh;
        @(posedge clk);
        if (rst) begin
            k = 0;
            for (int i = 0; i < 2; i++) begin
                m_score[i] = 0; m_ovf[i] = 0; m_seg[i] = 7'h7F; m_an[i] = '1;
            end
        end else begin
            k++;
            for (int i = 0; i < 2; i++) begin
                if (k >= DIV && (k % DIV) == 0) begin
                    d     = N - 1 - ((k / DIV - 1) % N);
                    dig   = (m_score[i] / pow10(d)) % 10;
                    blank = 0;
`ifdef SCORE_DISPLAY_BLANK_EN
                    blank = (d >= 1) && (m_score[i] < pow10(d));
`endif
                    if (blank) begin
                        m_seg[i] = 7'h7F; m_an[i] = '1;
                    end else begin
                        oh = '0; oh[d] = 1'b1;
                        m_seg[i] = glyph[dig]; m_an[i] = ~oh;
                    end
                end
                if (clear) begin
                    m_score[i] = 0; m_ovf[i] = 0;
                end else if (add_pulse && !pause) begin
                    v = (int'(add_value) > 9) ? 9 : int'(add_value);
                    s = m_score[i] + v;
                    if (s >= pow10(N)) begin
                        m_ovf[i] = 1;
                        s = (i == 0) ? pow10(N) - 1 : s - pow10(N);
                    end
                    m_score[i] = s;
                end
            end
        end
        #1;
        check("model_score_sat", 32'(score_s), 32'(to_bcd(m_score[0])));
        check("model_ovf_sat",   32'(ovf_s),   32'(m_ovf[0]));
        check("model_seg_sat",   32'(seg_s),   32'(m_seg[0]));
        check("model_an_sat",    32'(an_s),    32'(m_an[0]));
        check("model_score_wrap", 32'(score_w), 32'(to_bcd(m_score[1])));
        check("model_ovf_wrap",   32'(ovf_w),   32'(m_ovf[1]));
        check("model_seg_wrap",   32'(seg_w),   32'(m_seg[1]));
        check("model_an_wrap",    32'(an_w),    32'(m_an[1]));
    endtask

    task automatic do_reset();
        rst = 1'b1; add_pulse = 1'b0; clear = 1'b0; pause = 1'b0; add_value = 4'd0;
        repeat (3) step();
        rst = 1'b0;
    endtask

    // Bounded wait for the cycle on which an first becomes target
    task automatic wait_an(input logic [N-1:0] target, output bit ok);
        logic [N-1:0] prev;
        ok = 0;
        for (int i = 0; i < 10 * N * DIV && !ok; i++) begin
            prev = an_s;
            step();
            if (an_s == target && prev != target) ok = 1;
        end
        check("scan_sync", 32'(ok), 32'd1);
    endtask

    vec_t vecs [22];

    initial begin
        bit ok;
        logic [N-1:0] exp_an [4];
        logic [N-1:0] want_an;
        logic [6:0]   want_seg;

        glyph = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
        vecs = '{
            '{0, 0, 1, 12, 16'h0009, 0}, '{0, 0, 1,  9, 16'h0018, 0},
            '{0, 1, 1,  5, 16'h0018, 0}, '{0, 0, 1,  0, 16'h0018, 0},
            '{0, 0, 0,  7, 16'h0018, 0}, '{1, 0, 1,  7, 16'h0000, 0},
            '{0, 0, 1,  9, 16'h0009, 0}, '{0, 0, 1,  9, 16'h0018, 0},
            '{0, 0, 1,  9, 16'h0027, 0}, '{0, 0, 1,  9, 16'h0036, 0},
            '{0, 0, 1,  9, 16'h0045, 0}, '{0, 0, 1,  9, 16'h0054, 0},
            '{0, 0, 1,  9, 16'h0063, 0}, '{0, 0, 1,  9, 16'h0072, 0},
            '{0, 0, 1,  9, 16'h0081, 0}, '{0, 0, 1,  9, 16'h0090, 0},
            '{0, 0, 1,  8, 16'h0098, 0}, '{0, 0, 1,  5, 16'h0103, 0},
            '{0, 0, 1,  3, 16'h0106, 0}, '{0, 0, 1,  3, 16'h0109, 0},
            '{0, 0, 1,  3, 16'h0112, 0}, '{1, 0, 0,  0, 16'h0000, 0}
        };

        // Reset and first lit digit
        do_reset();
        check("reset_an",  32'(an_s),  32'hF);
        check("reset_seg", 32'(seg_s), 32'h7F);
        for (int i = 1; i <= DIV; i++) begin
            step();
            check("first_digit_an", 32'(an_s), (i == DIV) ? 32'h7 : 32'hF);
        end

        // Table: carry chain, clamping, pause, clear priority, back-to-back adds
        foreach (vecs[i]) begin
            clear = vecs[i].clr; pause = vecs[i].pse;
            add_pulse = vecs[i].add; add_value = vecs[i].val;
            step();
            check("vec_score_sat",  32'(score_s), 32'(vecs[i].exp_score));
            check("vec_ovf_sat",    32'(ovf_s),   32'(vecs[i].exp_ovf));
            check("vec_score_wrap", 32'(score_w), 32'(vecs[i].exp_score));
            check("vec_ovf_wrap",   32'(ovf_w),   32'(vecs[i].exp_ovf));
        end
        clear = 0; pause = 0; add_pulse = 0;

        // Overflow: reach 9995, then add 7
        add_pulse = 1; add_value = 4'd9;
        repeat (1110) step();
        add_value = 4'd5; step();
        check("pre_ovf_sat",  32'(score_s), 32'h9995);
        check("pre_ovf_wrap", 32'(score_w), 32'h9995);
        add_value = 4'd7; step();
        check("sat_score",  32'(score_s), 32'h9999);
        check("sat_ovf",    32'(ovf_s),   32'd1);
        check("wrap_score", 32'(score_w), 32'h0002);
        check("wrap_ovf",   32'(ovf_w),   32'd1);
        add_value = 4'd0; step();
        check("sat_plus0_score", 32'(score_s), 32'h9999);
        check("sat_plus0_ovf",   32'(ovf_s),   32'd1);
        add_pulse = 0; clear = 1; step(); clear = 0;
        check("clear_score", 32'(score_s), 32'h0000);
        check("clear_ovf",   32'(ovf_s),   32'd0);
        check("clear_ovf_wrap", 32'(ovf_w), 32'd0);

        // Scan order with 1234
        do_reset();
        add_pulse = 1; add_value = 4'd9;
        repeat (137) step();
        add_value = 4'd1; step();
        add_pulse = 0;
        repeat (8) step();
        exp_an = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};
        wait_an(4'b0111, ok);
        for (int s = 0; s < 4; s++) begin
            for (int c = 0; c < DIV; c++) begin
                check("scan_an",  32'(an_s),  32'(exp_an[s]));
                check("scan_seg", 32'(seg_s), 32'(glyph[s + 1]));
                step();
            end
        end
        check("scan_wrap_an", 32'(an_s), 32'h7);

        // Leading zeros with 0007
        do_reset();
        add_pulse = 1; add_value = 4'd7; step();
        add_pulse = 0;
        repeat (8) step();
`ifdef SCORE_DISPLAY_BLANK_EN
        want_an = 4'b1110; want_seg = glyph[7];
`else
        want_an = 4'b0111; want_seg = glyph[0];
`endif
        wait_an(want_an, ok);
        check("lz_seg", 32'(seg_s), 32'(want_seg));
        repeat (DIV) step();
`ifdef SCORE_DISPLAY_BLANK_EN
        check("lz_next_an",  32'(an_s),  32'hF);
        check("lz_next_seg", 32'(seg_s), 32'h7F);
`else
        check("lz_next_an",  32'(an_s),  32'hB);
        check("lz_next_seg", 32'(seg_s), 32'(glyph[0]));
`endif

        // Randomised traffic against the model
        for (int i = 0; i < 3000; i++) begin
            rst       = ($urandom % 400) == 0;
            clear     = ($urandom % 300) == 0;
            pause     = ($urandom % 4) == 0;
            add_pulse = ($urandom % 2) == 0;
            add_value = 4'($urandom % 16);
            step();
        end
        rst = 0; clear = 0; pause = 0; add_pulse = 0;
        step();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
`default_nettype wire
